// File: rtl/optoml_stream_pkg.sv
// Shared stream defaults and width helpers for the optoml stream blocks.
package optoml_stream_pkg;

   localparam int DEFAULT_DATA_WIDTH  = 32;
   localparam int DEFAULT_SLICE_WIDTH = 8;

   // Returns 0 for an unusable pairing so callers can reject it with one test.
   function automatic int ratio_f(input int in_w, input int out_w);
      if (out_w <= 0 || in_w <= 0 || (in_w % out_w) != 0)
         return 0;
      return in_w / out_w;
   endfunction

endpackage

// File: rtl/optoml_width_downsizer_if.sv
// Valid/ready bundle for the width downsizer: wide word in, narrow slices out.
interface optoml_width_downsizer_if
   import optoml_stream_pkg::*;
#(
   parameter int IN_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int OUT_WIDTH = DEFAULT_SLICE_WIDTH
);

   logic                 in_valid;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_ready;
   logic                 out_valid;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;
   logic                 out_ready;

   // master = the surrounding environment, slave = the downsizer itself
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/optoml_width_downsizer.sv
// Splits each IN_WIDTH word into RATIO slices, LSB slice first, marking the
// final slice with out_last; a new word can load on the last-slice handshake.
module optoml_width_downsizer
   import optoml_stream_pkg::*;
#(
   parameter int IN_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int OUT_WIDTH = DEFAULT_SLICE_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   optoml_width_downsizer_if.slave  bus
);

   localparam int RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);
   localparam int IDX_W = (RATIO < 2) ? 1 : $clog2(RATIO);

   if (RATIO < 2) begin : g_bad_ratio
      $error("optoml_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
   end

   logic                busy;
   logic [IDX_W-1:0]    idx;
   logic [IN_WIDTH-1:0] shreg;

   logic is_last;
   logic slice_fire;
   logic accept;

   assign is_last    = busy && (idx == IDX_W'(RATIO - 1));
   assign slice_fire = busy && bus.out_ready;

   // out_ready -> in_ready is the only combinational path through the block.
   assign bus.in_ready  = !reset && (!busy || (bus.out_ready && is_last));
   assign accept        = bus.in_valid && bus.in_ready;

   assign bus.out_valid = busy;
   assign bus.out_data  = shreg[OUT_WIDTH-1:0];
   assign bus.out_last  = is_last;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would chain updates within one edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy  <= 1'b0;
         idx   <= '0;
         shreg <= '0;
      end else if (accept) begin
         // Covers both an idle load and the no-bubble reload on the last slice.
         busy  <= 1'b1;
         idx   <= '0;
         shreg <= bus.in_data;
      end else if (slice_fire) begin
         if (is_last) begin
            busy <= 1'b0;
            idx  <= '0;
         end else begin
            idx   <= idx + 1'b1;
            shreg <= shreg >> OUT_WIDTH;
         end
      end
   end

endmodule

// File: tb/tb_optoml_width_downsizer.sv
// Directed self-checking bench for optoml_width_downsizer (32 -> 8 bits).
module tb_optoml_width_downsizer;

   localparam int IN_W  = 32;
   localparam int OUT_W = 8;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   optoml_width_downsizer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

   optoml_width_downsizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Advance to 2 time units after the next rising edge; inputs are driven
   // there and outputs sampled one unit later, well away from the edge.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEADBEEF;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid c%0d: got %b expected 0", c, bus.out_valid); end
         checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data c%0d: got %h expected 00", c, bus.out_data); end
         checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last c%0d: got %b expected 0", c, bus.out_last); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
      end
      tick();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_out_valid: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_single_word();
      logic [7:0] exp_b [4];
      exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      tick();
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA1B2C3D4;
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b expected 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid s%0d: got %b expected 1", i, bus.out_valid); end
         checks++; if (bus.out_data !== exp_b[i]) begin errors++; $display("FAIL single_data s%0d: got %h expected %h", i, bus.out_data, exp_b[i]); end
         checks++; if (bus.out_last !== (i == 3)) begin errors++; $display("FAIL single_last s%0d: got %b expected %b", i, bus.out_last, (i == 3)); end
         tick();
      end
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_after: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h03020100;
      bus.out_ready = 1'b1;
      tick();
      bus.in_data = 32'h07060504;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = (i < 7);
         #1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid s%0d: got %b expected 1", i, bus.out_valid); end
         checks++; if (bus.out_data !== 8'(i)) begin errors++; $display("FAIL b2b_data s%0d: got %h expected %h", i, bus.out_data, 8'(i)); end
         checks++; if (bus.out_last !== (i % 4 == 3)) begin errors++; $display("FAIL b2b_last s%0d: got %b expected %b", i, bus.out_last, (i % 4 == 3)); end
         checks++; if (bus.in_ready !== (i == 3 || i == 7)) begin errors++; $display("FAIL b2b_in_ready s%0d: got %b expected %b", i, bus.in_ready, (i == 3 || i == 7)); end
         tick();
      end
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      logic [7:0] tail [3];
      tail = '{8'hC3, 8'hB2, 8'hA1};
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA1B2C3D4;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      #1;
      checks++; if (bus.out_data !== 8'hD4) begin errors++; $display("FAIL bp_first: got %h expected D4", bus.out_data); end
      tick();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", c, bus.out_valid); end
         checks++; if (bus.out_data !== 8'hC3) begin errors++; $display("FAIL bp_data c%0d: got %h expected C3", c, bus.out_data); end
         checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL bp_last c%0d: got %b expected 0", c, bus.out_last); end
         checks++; if (dut.idx !== 2'd1) begin errors++; $display("FAIL bp_idx c%0d: got %0d expected 1", c, dut.idx); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
         tick();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.out_data !== tail[i]) begin errors++; $display("FAIL bp_resume s%0d: got %h expected %h", i, bus.out_data, tail[i]); end
         checks++; if (bus.out_last !== (i == 2)) begin errors++; $display("FAIL bp_resume_last s%0d: got %b expected %b", i, bus.out_last, (i == 2)); end
         tick();
      end
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_after: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_last_stall();
      logic [7:0] nxt [4];
      nxt = '{8'h88, 8'h77, 8'h66, 8'h55};
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA1B2C3D4;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h55667788;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (bus.out_data !== 8'hA1) begin errors++; $display("FAIL lst_data c%0d: got %h expected A1", c, bus.out_data); end
         checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL lst_last c%0d: got %b expected 1", c, bus.out_last); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lst_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lst_release_ready: got %b expected 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lst_next_valid s%0d: got %b expected 1", i, bus.out_valid); end
         checks++; if (bus.out_data !== nxt[i]) begin errors++; $display("FAIL lst_next_data s%0d: got %h expected %h", i, bus.out_data, nxt[i]); end
         checks++; if (bus.out_last !== (i == 3)) begin errors++; $display("FAIL lst_next_last s%0d: got %b expected %b", i, bus.out_last, (i == 3)); end
         tick();
      end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] fresh [4];
      fresh = '{8'h44, 8'h33, 8'h22, 8'h11};
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA1B2C3D4;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      #1;
      checks++; if (bus.out_data !== 8'hB2) begin errors++; $display("FAIL mid_pre_reset: got %h expected B2", bus.out_data); end
      reset = 1'b1;
      tick();
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h expected 00", bus.out_data); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL mid_last: got %b expected 0", bus.out_last); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", bus.in_ready); end
      tick();
      reset        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11223344;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got %b expected 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b expected 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.out_data !== fresh[i]) begin errors++; $display("FAIL mid_new_data s%0d: got %h expected %h", i, bus.out_data, fresh[i]); end
         checks++; if (bus.out_last !== (i == 3)) begin errors++; $display("FAIL mid_new_last s%0d: got %b expected %b", i, bus.out_last, (i == 3)); end
         tick();
      end
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_idle_after: got %b expected 0", bus.out_valid); end
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_last_stall();
      test_reset_mid_word();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
